usb_link_controller: RTL and testbench
======================================

Name: usb_link_controller

Overview:
- Half-duplex bus-ownership sequencer for the USB transceiver.
- Watches line state (Data_In, Diff) and drives the receiver's Active and Tx_Ready inputs.
- Grants the bus to the transmitter only after a turnaround gap, and drives the transmit EOP (SE0).
- Tracks per-packet received byte count, receive errors and receive timeout.

Parameters:
- TURNAROUND_CYCLES, 2: idle gap (clocks) between bus-direction changes; minimum 1.
- EOP_SE0_CYCLES, 2: SE0 length (clocks) required to accept a received EOP; also the SE0 length driven after transmit.
- RX_TIMEOUT, 64: maximum clocks between Rx_Valid pulses while receiving.
- CNT_W, 8: width of Rx_Byte_Count.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Data_In  in  1  decoded line bit; 1 = J (idle), 0 = K.
- Diff  in  1  1 = valid differential line, 0 = SE0.
- Rx_Valid  in  1  receiver byte strobe, one clock per byte.
- Rx_Error  in  1  receiver error strobe.
- Tx_Req  in  1  transmit request; held until Tx_Ack.
- Tx_Done  in  1  transmitter last-bit pulse.
- Active  out  1  receiver enable (connects to receiver Active).
- Tx_Ready  out  1  1 while transmitter owns bus (connects to receiver Tx_Ready).
- Tx_Grant  out  1  transmitter may shift data.
- Se0_Drive  out  1  force SE0 on line (transmit EOP).
- Tx_Ack  out  1  one-clock pulse, transmit complete.
- Pkt_Done  out  1  one-clock pulse, valid receive EOP accepted.
- Timeout_Err  out  1  one-clock pulse, receive timeout.
- Rx_Err_Flag  out  1  sticky receive-error flag.
- Rx_Byte_Count  out  CNT_W  bytes in current/last received packet.
- Busy  out  1  state != IDLE.

Behaviour:
- Reset:
  - Rst=1 forces state IDLE and all counters to 0 immediately, independent of Clk.
  - All outputs are 0 while Rst=1.
  - Applies mid-packet: no Pkt_Done, Tx_Ack or Timeout_Err is emitted for the aborted packet.
- Outputs:
  - Active, Tx_Ready, Tx_Grant, Se0_Drive and Busy are Moore decodes of the registered state.
  - Pulse outputs and Rx_Err_Flag are registered.
- IDLE:
  - All outputs 0 except Rx_Byte_Count and Rx_Err_Flag, which hold.
  - Diff=1 and Data_In=0 sampled at an edge -> RX. At entry, Rx_Byte_Count and Rx_Err_Flag clear and the idle counter clears.
  - Otherwise Tx_Req=1 -> TA.
  - Simultaneous start and Tx_Req: receive wins; Tx_Req stays pending.
- RX: Active=1, Busy=1.
  - Rx_Valid increments Rx_Byte_Count (saturates at all-ones) and clears the idle counter; otherwise the idle counter increments.
  - Rx_Error sets Rx_Err_Flag; state does not change.
  - Diff=0 -> RX_EOP, SE0 counter = 1.
  - Idle counter reaching RX_TIMEOUT -> Timeout_Err pulse on that edge and state -> TA.
  - Diff=0 on the same edge as timeout: timeout wins.
- RX_EOP: Active=1.
  - Diff=0 increments the SE0 counter (saturating).
  - Diff=1 with SE0 counter >= EOP_SE0_CYCLES -> TA, plus a Pkt_Done pulse.
  - Diff=1 with SE0 counter < EOP_SE0_CYCLES -> back to RX (glitch); the idle counter continues.
  - Rx_Valid in this state still counts.
- TA: all bus outputs 0, Busy=1.
  - Lasts exactly TURNAROUND_CYCLES clocks.
  - Then Tx_Req=1 -> TX, else IDLE.
- TX: Tx_Ready=1, Tx_Grant=1.
  - Line start conditions are ignored.
  - Tx_Done -> TX_EOP.
- TX_EOP: Tx_Ready=1, Se0_Drive=1, Tx_Grant=0.
  - Lasts exactly EOP_SE0_CYCLES clocks.
  - Then IDLE, plus a Tx_Ack pulse on the transition edge.
  - Requester drops Tx_Req after Tx_Ack. Tx_Req still high in IDLE starts a new TA (back-to-back transmit).
- Latency:
  - Line start sampled at edge k -> Active=1 after edge k.
  - Pkt_Done is high after the edge sampling Diff=1 and low after the next edge.
- Encoding: 3-bit states IDLE=0, RX=1, RX_EOP=2, TA=3, TX=4, TX_EOP=5. Unused codes -> IDLE.

Test Plan:
- Reset mid-RX:
  - Stimulus: assert Rst between edges after 2 bytes.
  - Required: Active, Busy and Rx_Byte_Count fall before the next edge; no Pkt_Done after release.
- Nominal receive:
  - Stimulus: Diff=1, Data_In=0; then 3 Rx_Valid pulses; then Diff=0 for 2 clocks, then Diff=1.
  - Required: Active high the edge after start; Pkt_Done one clock; Rx_Byte_Count=3.
  - Required: Busy stays high exactly 2 more clocks (TA), then IDLE.
- SE0 glitch:
  - Stimulus: Diff=0 for 1 clock mid-packet.
  - Required: returns to RX, Active stays 1, no Pkt_Done; a later valid 2-clock EOP completes normally.
- Timeout:
  - Stimulus: enter RX with no Rx_Valid.
  - Required: Timeout_Err pulses on the 64th clock; Active drops; Busy drops after 2 further clocks.
- Priority and transmit:
  - Stimulus: Tx_Req=1 on the same edge as the line start; receive a 1-byte packet.
  - Required: RX wins. After EOP, TA lasts 2 clocks, then Tx_Grant=1 and Tx_Ready=1.
  - Stimulus: Tx_Done pulse.
  - Required: Se0_Drive=1 for 2 clocks, then Tx_Ack one clock, then IDLE.
- Sticky error:
  - Stimulus: Rx_Error pulse during RX, then a complete packet.
  - Required: Rx_Err_Flag stays 1 through IDLE; clears only at the next RX entry.

Source files
------------

// File: rtl/usb_link_controller.sv
// Half-duplex bus-ownership sequencer between USB receiver and transmitter.
// Moore bus-enable outputs follow the registered state; pulses are registered (one clock).
// No backpressure: Tx_Req is held by the requester until Tx_Ack, other inputs are strobes.
module usb_link_controller #(
  parameter int TURNAROUND_CYCLES = 2,
  parameter int EOP_SE0_CYCLES    = 2,
  parameter int RX_TIMEOUT        = 64,
  parameter int CNT_W             = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Data_In,
  input  logic             Diff,
  input  logic             Rx_Valid,
  input  logic             Rx_Error,
  input  logic             Tx_Req,
  input  logic             Tx_Done,
  output logic             Active,
  output logic             Tx_Ready,
  output logic             Tx_Grant,
  output logic             Se0_Drive,
  output logic             Tx_Ack,
  output logic             Pkt_Done,
  output logic             Timeout_Err,
  output logic             Rx_Err_Flag,
  output logic [CNT_W-1:0] Rx_Byte_Count,
  output logic             Busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RX     = 3'd1,
    S_RX_EOP = 3'd2,
    S_TA     = 3'd3,
    S_TX     = 3'd4,
    S_TX_EOP = 3'd5
  } state_t;

  localparam int CW = 16;
  localparam logic [CW-1:0] TO_LAST  = CW'(RX_TIMEOUT - 1);
  localparam logic [CW-1:0] TA_LAST  = CW'(TURNAROUND_CYCLES - 1);
  localparam logic [CW-1:0] EOP_LAST = CW'(EOP_SE0_CYCLES - 1);
  localparam logic [CW-1:0] EOP_MIN  = CW'(EOP_SE0_CYCLES);

  state_t          state;
  logic [CW-1:0]   idle_cnt;   // clocks since last Rx_Valid while receiving
  logic [CW-1:0]   se0_cnt;    // SE0 length seen on a candidate receive EOP
  logic [CW-1:0]   phase_cnt;  // shared by TA and TX_EOP, cleared on entry to each

  logic line_start;
  assign line_start = Diff && !Data_In;

  // Main sequencer: state, counters, registered pulses and sticky receive status.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state         <= S_IDLE;
      idle_cnt      <= '0;
      se0_cnt       <= '0;
      phase_cnt     <= '0;
      Pkt_Done      <= 1'b0;
      Tx_Ack        <= 1'b0;
      Timeout_Err   <= 1'b0;
      Rx_Err_Flag   <= 1'b0;
      Rx_Byte_Count <= '0;
    end else begin
      Pkt_Done    <= 1'b0;
      Tx_Ack      <= 1'b0;
      Timeout_Err <= 1'b0;
      case (state)
        S_IDLE: begin
          // Receive has priority; a pending Tx_Req is served after the packet.
          if (line_start) begin
            state         <= S_RX;
            Rx_Byte_Count <= '0;
            Rx_Err_Flag   <= 1'b0;
            idle_cnt      <= '0;
          end else if (Tx_Req) begin
            state     <= S_TA;
            phase_cnt <= '0;
          end
        end
        S_RX: begin
          if (Rx_Error) Rx_Err_Flag <= 1'b1;
          if (Rx_Valid) begin
            idle_cnt <= '0;
            if (Rx_Byte_Count != {CNT_W{1'b1}}) Rx_Byte_Count <= Rx_Byte_Count + 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
          // Timeout beats a simultaneous SE0.
          if (!Rx_Valid && idle_cnt == TO_LAST) begin
            Timeout_Err <= 1'b1;
            state       <= S_TA;
            phase_cnt   <= '0;
          end else if (!Diff) begin
            state   <= S_RX_EOP;
            se0_cnt <= CW'(1);
          end
        end
        S_RX_EOP: begin
          if (Rx_Error) Rx_Err_Flag <= 1'b1;
          if (Rx_Valid && Rx_Byte_Count != {CNT_W{1'b1}}) Rx_Byte_Count <= Rx_Byte_Count + 1'b1;
          if (!Diff) begin
            if (se0_cnt != {CW{1'b1}}) se0_cnt <= se0_cnt + 1'b1;
          end else if (se0_cnt >= EOP_MIN) begin
            Pkt_Done  <= 1'b1;
            state     <= S_TA;
            phase_cnt <= '0;
          end else begin
            // Short SE0 is a glitch; the idle counter keeps its value.
            state <= S_RX;
          end
        end
        S_TA: begin
          if (phase_cnt == TA_LAST) state <= Tx_Req ? S_TX : S_IDLE;
          else phase_cnt <= phase_cnt + 1'b1;
        end
        S_TX: begin
          if (Tx_Done) begin
            state     <= S_TX_EOP;
            phase_cnt <= '0;
          end
        end
        S_TX_EOP: begin
          if (phase_cnt == EOP_LAST) begin
            state  <= S_IDLE;
            Tx_Ack <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bus-control outputs decoded from the registered state.
  always_comb begin
    Active    = (state == S_RX) || (state == S_RX_EOP);
    Tx_Ready  = (state == S_TX) || (state == S_TX_EOP);
    Tx_Grant  = (state == S_TX);
    Se0_Drive = (state == S_TX_EOP);
    Busy      = (state != S_IDLE);
  end

endmodule

// File: tb/tb_usb_link_controller.sv
// Directed bench for usb_link_controller with a scoreboard of expected pulse events.
// Samples outputs 1 time unit after each rising edge; inputs driven between edges.
// Every pulse seen must match the head of the expected-event queue.
module tb_usb_link_controller;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Data_In, Diff, Rx_Valid, Rx_Error, Tx_Req, Tx_Done;
  logic       Active, Tx_Ready, Tx_Grant, Se0_Drive, Tx_Ack, Pkt_Done;
  logic       Timeout_Err, Rx_Err_Flag, Busy;
  logic [7:0] Rx_Byte_Count;

  localparam logic [2:0] EV_PKT = 3'b001;
  localparam logic [2:0] EV_ACK = 3'b010;
  localparam logic [2:0] EV_TO  = 3'b100;

  typedef struct packed {
    logic [2:0] ev;
    logic [7:0] cnt;
    logic       chk_cnt;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  logic [2:0] last_ev;

  usb_link_controller dut (
    .Clk(Clk), .Rst(Rst), .Data_In(Data_In), .Diff(Diff),
    .Rx_Valid(Rx_Valid), .Rx_Error(Rx_Error), .Tx_Req(Tx_Req), .Tx_Done(Tx_Done),
    .Active(Active), .Tx_Ready(Tx_Ready), .Tx_Grant(Tx_Grant), .Se0_Drive(Se0_Drive),
    .Tx_Ack(Tx_Ack), .Pkt_Done(Pkt_Done), .Timeout_Err(Timeout_Err),
    .Rx_Err_Flag(Rx_Err_Flag), .Rx_Byte_Count(Rx_Byte_Count), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] ev, input logic [7:0] cnt, input logic chk_cnt);
    exp_t e;
    e.ev = ev;
    e.cnt = cnt;
    e.chk_cnt = chk_cnt;
    sb.push_back(e);
  endtask

  // Advance one clock and reconcile any pulse with the scoreboard.
  task automatic tick();
    exp_t e;
    logic [2:0] ev;
    @(posedge Clk);
    #1;
    ev = {Timeout_Err, Tx_Ack, Pkt_Done};
    last_ev = ev;
    if (ev != 3'b000) begin
      if (sb.size() == 0) begin
        chk("unexpected_event", 32'(ev), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("event_kind", 32'(ev), 32'(e.ev));
        if (e.chk_cnt) chk("pkt_byte_count", 32'(Rx_Byte_Count), 32'(e.cnt));
      end
    end
  endtask

  task automatic start_rx();
    Data_In = 1'b0;
    tick();
    Data_In = 1'b1;
  endtask

  task automatic bytes(input int n);
    Rx_Valid = 1'b1;
    for (int i = 0; i < n; i++) tick();
    Rx_Valid = 1'b0;
  endtask

  // Two-clock SE0 then J: the edge sampling J produces Pkt_Done.
  task automatic eop(input logic [7:0] cnt);
    Diff = 1'b0;
    tick();
    tick();
    Diff = 1'b1;
    push(EV_PKT, cnt, 1'b1);
    tick();
  endtask

  initial begin
    int seen;
    Rst = 1'b1; Data_In = 1'b1; Diff = 1'b1; Rx_Valid = 1'b0;
    Rx_Error = 1'b0; Tx_Req = 1'b0; Tx_Done = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_active", 32'(Active), 32'd0);
    chk("rst_count", 32'(Rx_Byte_Count), 32'd0);
    chk("rst_errflag", 32'(Rx_Err_Flag), 32'd0);
    chk("rst_txready", 32'(Tx_Ready), 32'd0);
    Rst = 1'b0;
    tick();
    chk("idle_busy", 32'(Busy), 32'd0);

    // Nominal receive of three bytes.
    start_rx();
    chk("rx_active", 32'(Active), 32'd1);
    chk("rx_busy", 32'(Busy), 32'd1);
    bytes(3);
    chk("rx_count3", 32'(Rx_Byte_Count), 32'd3);
    eop(8'd3);
    chk("eop_active_off", 32'(Active), 32'd0);
    chk("ta_busy1", 32'(Busy), 32'd1);
    tick();
    chk("ta_busy2", 32'(Busy), 32'd1);
    tick();
    chk("ta_done_idle", 32'(Busy), 32'd0);

    // One-clock SE0 glitch returns to RX, then a valid EOP.
    start_rx();
    bytes(1);
    Diff = 1'b0;
    tick();
    Diff = 1'b1;
    tick();
    chk("glitch_active", 32'(Active), 32'd1);
    chk("glitch_busy", 32'(Busy), 32'd1);
    bytes(1);
    eop(8'd2);
    tick();
    tick();
    chk("glitch_idle", 32'(Busy), 32'd0);

    // Sticky error flag survives into IDLE.
    start_rx();
    Rx_Error = 1'b1;
    tick();
    Rx_Error = 1'b0;
    chk("err_set", 32'(Rx_Err_Flag), 32'd1);
    chk("err_state_rx", 32'(Active), 32'd1);
    bytes(1);
    eop(8'd1);
    tick();
    tick();
    chk("err_idle_busy", 32'(Busy), 32'd0);
    chk("err_sticky_idle", 32'(Rx_Err_Flag), 32'd1);

    // Next RX entry clears status, then idles into a timeout.
    start_rx();
    chk("err_cleared", 32'(Rx_Err_Flag), 32'd0);
    chk("count_cleared", 32'(Rx_Byte_Count), 32'd0);
    push(EV_TO, 8'd0, 1'b0);
    seen = 0;
    for (int i = 1; i <= 100 && seen == 0; i++) begin
      tick();
      if (last_ev[2]) seen = i;
    end
    chk("timeout_clock", 32'(seen), 32'd64);
    chk("timeout_active", 32'(Active), 32'd0);
    chk("timeout_busy", 32'(Busy), 32'd1);
    tick();
    chk("timeout_ta_busy", 32'(Busy), 32'd1);
    tick();
    chk("timeout_idle", 32'(Busy), 32'd0);

    // Tx_Req together with line start: receive wins, transmit follows.
    Tx_Req = 1'b1;
    start_rx();
    chk("prio_active", 32'(Active), 32'd1);
    chk("prio_grant", 32'(Tx_Grant), 32'd0);
    bytes(1);
    eop(8'd1);
    chk("prio_ta_grant", 32'(Tx_Grant), 32'd0);
    tick();
    chk("prio_ta2_grant", 32'(Tx_Grant), 32'd0);
    tick();
    chk("tx_grant", 32'(Tx_Grant), 32'd1);
    chk("tx_ready", 32'(Tx_Ready), 32'd1);
    chk("tx_active", 32'(Active), 32'd0);
    Data_In = 1'b0;
    tick();
    Data_In = 1'b1;
    chk("tx_ignore_start", 32'(Tx_Grant), 32'd1);
    Tx_Done = 1'b1;
    tick();
    Tx_Done = 1'b0;
    chk("txeop_se0_1", 32'(Se0_Drive), 32'd1);
    chk("txeop_grant", 32'(Tx_Grant), 32'd0);
    chk("txeop_ready", 32'(Tx_Ready), 32'd1);
    tick();
    chk("txeop_se0_2", 32'(Se0_Drive), 32'd1);
    push(EV_ACK, 8'd0, 1'b0);
    tick();
    Tx_Req = 1'b0;
    chk("ack_seen", 32'(last_ev), 32'(EV_ACK));
    chk("ack_se0_off", 32'(Se0_Drive), 32'd0);
    chk("ack_idle", 32'(Busy), 32'd0);
    tick();
    chk("after_ack_idle", 32'(Busy), 32'd0);

    // Reset asserted between edges mid-packet.
    start_rx();
    bytes(2);
    chk("mid_count2", 32'(Rx_Byte_Count), 32'd2);
    #2;
    Rst = 1'b1;
    #1;
    chk("mid_rst_active", 32'(Active), 32'd0);
    chk("mid_rst_busy", 32'(Busy), 32'd0);
    chk("mid_rst_count", 32'(Rx_Byte_Count), 32'd0);
    tick();
    Rst = 1'b0;
    Diff = 1'b0;
    tick();
    tick();
    Diff = 1'b1;
    tick();
    tick();
    tick();
    chk("post_rst_idle", 32'(Busy), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
